de_morgan_sweep: RTL and testbench
==================================

Name: de_morgan_sweep

Overview:
- Synthesisable, self-checking exhaustive stimulus engine for N-input De Morgan gate implementations.
- On `start`, it drives every one of the 2^WIDTH input patterns to an external gate under test and holds each for HOLD_CYCLES.
- It samples the gate output and compares it against an internal reference for the selected law, then reports pass/fail, error count and first failing pattern.
- Sits beside the gate-level lab modules as an on-chip replacement for the free-running toggle benches.

Parameters:
- WIDTH, 2, number of gate inputs (1..16).
- HOLD_CYCLES, 2, clock cycles each pattern is held before sampling (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; honoured only in IDLE.
- mode  input  1  law select: 0 = NAND form, expected ~(&x) == |~x; 1 = NOR form, expected ~(|x) == &~x.
- dut_in  output  WIDTH  pattern presented to the gate under test.
- dut_out  input  1  gate-under-test output.
- busy  output  1  high while sweeping.
- done  output  1  one-cycle pulse at sweep end.
- pass  output  1  high when the last sweep had zero errors; valid from `done` until the next `start`.
- err_count  output  WIDTH+1  mismatches in the last sweep.
- first_err  output  WIDTH  first mismatching pattern; 0 if none.

Behaviour:
- Reset values: state IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err=0; hold and pattern counters 0.
- IDLE:
  - When start=1, latch `mode` internally; `mode` changes mid-sweep are ignored.
  - Next cycle: state DRIVE, busy=1, dut_in=pattern 0, hold counter 0, err_count=0, first_err=0, pass=0.
- DRIVE:
  - The hold counter increments each cycle.
  - On the cycle where hold counter == HOLD_CYCLES-1, sample `dut_out` against the reference for the current dut_in.
  - On mismatch:
    - err_count increments. It cannot overflow: max 2^WIDTH fits in WIDTH+1 bits.
    - On the first mismatch only, first_err captures the pattern.
  - On the same edge, if the pattern index is not the last, advance to the next pattern and clear the hold counter. If it is the last (index 2^WIDTH-1), go to DONE.
- DONE:
  - Exactly one cycle: done=1, busy=0, pass=(err_count==0) including any final-pattern error.
  - dut_in returns to 0. Then IDLE.
- Latency: start to first dut_in = 1 cycle; busy high for exactly 2^WIDTH*HOLD_CYCLES cycles; done follows on the next cycle.
- The pattern index counter is WIDTH+1 bits wide, so WIDTH=16 terminates without aliasing.
- start while busy or in DONE: ignored, no restart.
- start held high continuously: a new sweep begins on the cycle after DONE.
- rst_n low mid-sweep: immediate return to reset values; partial results discarded.
- Reference model is purely combinational on dut_in and the latched mode; no registered delay.

Optional Feature:
- DE_MORGAN_SWEEP_GRAY_EN defined: pattern sequence is Gray code, index i drives i ^ (i>>1), so exactly one input toggles per step (glitch-hazard testing). first_err reports the driven Gray pattern, not the index.
- Undefined: plain binary count order 0,1,2,...; no Gray logic synthesised.

Decomposition:
- Package de_morgan_pkg:
  - state enum (IDLE, DRIVE, DONE);
  - mode constants MODE_NAND=1'b0, MODE_NOR=1'b1;
  - function computing expected output from pattern and mode.
- Sub-module de_morgan_ref (combinational, parametrised by WIDTH): evaluates both sides of the selected law and outputs the expected value plus an internal-consistency flag; the flag is asserted equal in simulation.

Test Plan:
- WIDTH=2, HOLD=2, mode=0, DUT=2-input NAND -> dut_in 00,01,10,11 each 2 cycles; busy 8 cycles; done pulse; pass=1, err_count=0, first_err=00.
- Same configuration, DUT stuck-at-0 -> expected 1,1,1,0 -> err_count=3, first_err=00, pass=0.
- mode=1, DUT=AND gate -> NOR law expects 1,0,0,0, AND gives 0,0,0,1 -> err_count=2, first_err=00; repeat with NOR DUT -> pass=1.
- WIDTH=3, HOLD=1, NAND DUT: pulse start again at busy cycle 3 -> ignored, busy 8 cycles total; rst_n low at cycle 5 -> all outputs 0 immediately; a later start runs a full clean sweep, pass=1.
- DE_MORGAN_SWEEP_GRAY_EN, WIDTH=2 -> dut_in sequence 00,01,11,10; Hamming distance 1 between consecutive patterns, checked by assertion.
- WIDTH=16, HOLD=1, NAND DUT -> busy exactly 65536 cycles, err_count=0, index counter terminates without wrap.

Source files
------------

// File: rtl/de_morgan_pkg.sv
// Shared types and helpers for the De Morgan sweep engine.
//   state_e      : sweep controller states
//   MODE_NAND/NOR: law select encodings for the mode input
//   expected_out : reference gate output for a pattern under the selected law
package de_morgan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam logic MODE_NAND = 1'b0;
   localparam logic MODE_NOR  = 1'b1;

   localparam int MAX_WIDTH = 16;

   // Patterns narrower than MAX_WIDTH are zero-extended; the mask forces the
   // unused upper bits to the identity value of each reduction.
   function automatic logic expected_out(input logic [MAX_WIDTH-1:0] pat,
                                         input int                   width,
                                         input logic                 mode);
      logic [MAX_WIDTH-1:0] mask;
      mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
      if (mode == MODE_NAND) begin
         return ~(&(pat | ~mask));
      end
      return ~(|(pat & mask));
   endfunction

endpackage

// File: rtl/de_morgan_sweep_if.sv
// Bundle between a host / gate under test and the sweep engine.
//   start, mode   : host -> engine, sweep request and law select
//   dut_in        : engine -> gate, pattern being driven
//   dut_out       : gate -> engine, gate response
//   busy, done, pass, err_count, first_err : engine -> host, status/results
// slave is the engine side, master the host/gate side.
interface de_morgan_sweep_if #(parameter int WIDTH = 2);

   logic             start;
   logic             mode;
   logic [WIDTH-1:0] dut_in;
   logic             dut_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [WIDTH:0]   err_count;
   logic [WIDTH-1:0] first_err;

   modport master (
      output start, mode, dut_out,
      input  dut_in, busy, done, pass, err_count, first_err
   );

   modport slave (
      input  start, mode, dut_out,
      output dut_in, busy, done, pass, err_count, first_err
   );

endinterface

// File: rtl/de_morgan_ref.sv
// Combinational De Morgan reference.
//   pat        : pattern currently driven to the gate
//   mode       : latched law select (NAND or NOR form)
//   expected   : left-hand side of the selected law, ~(&x) or ~(|x)
//   consistent : high when both sides of the law agree for this pattern
module de_morgan_ref
   import de_morgan_pkg::*;
#(
   parameter int WIDTH = 2
) (
   input  logic [WIDTH-1:0] pat,
   input  logic             mode,
   output logic             expected,
   output logic             consistent
);

   logic lhs;
   logic rhs;

   always_comb begin
      lhs        = expected_out(MAX_WIDTH'(pat), WIDTH, mode);
      rhs        = (mode == MODE_NAND) ? |(~pat) : &(~pat);
      expected   = lhs;
      consistent = (lhs == rhs);
   end

endmodule

// File: rtl/de_morgan_sweep.sv
// Exhaustive stimulus/check engine for an external N-input De Morgan gate.
// Drives all 2^WIDTH patterns, holds each HOLD_CYCLES cycles, samples the
// gate output on the last hold cycle and compares against the reference.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : de_morgan_sweep_if slave (start/mode in, dut_in out,
//                dut_out in, busy/done/pass/err_count/first_err out)
// Build option: DE_MORGAN_SWEEP_GRAY_EN selects Gray-code pattern order.
//
// state | meaning
// IDLE  | waiting for start; results of last sweep held
// DRIVE | presenting patterns, counting hold cycles, checking on last cycle
// DONE  | one-cycle done pulse, pass valid, dut_in back to 0
module de_morgan_sweep
   import de_morgan_pkg::*;
#(
   parameter int WIDTH       = 2,
   parameter int HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   de_morgan_sweep_if.slave bus
);

   localparam logic [WIDTH:0] LAST_IDX  = {1'b0, {WIDTH{1'b1}}};
   localparam logic [7:0]     HOLD_LAST = 8'(HOLD_CYCLES - 1);

   function automatic logic [WIDTH-1:0] pattern_of(input logic [WIDTH-1:0] i);
`ifdef DE_MORGAN_SWEEP_GRAY_EN
      return i ^ (i >> 1);
`else
      return i;
`endif
   endfunction

   state_e           state_q,     state_d;
   logic             mode_q,      mode_d;
   logic [WIDTH:0]   idx_q,       idx_d;
   logic [7:0]       hold_q,      hold_d;
   logic [WIDTH:0]   err_count_q, err_count_d;
   logic [WIDTH-1:0] first_err_q, first_err_d;
   logic             pass_q,      pass_d;

   logic [WIDTH-1:0] cur_pat;
   logic             exp_out;
   logic             ref_ok;
   logic             mismatch;

   assign cur_pat = pattern_of(idx_q[WIDTH-1:0]);

   de_morgan_ref #(.WIDTH(WIDTH)) u_ref (
      .pat        (cur_pat),
      .mode       (mode_q),
      .expected   (exp_out),
      .consistent (ref_ok)
   );

   assign mismatch = (bus.dut_out != exp_out);

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      idx_d       = idx_q;
      hold_d      = hold_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;
      pass_d      = pass_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d     = DRIVE;
               mode_d      = bus.mode;
               idx_d       = '0;
               hold_d      = '0;
               err_count_d = '0;
               first_err_d = '0;
               pass_d      = 1'b0;
            end
         end
         DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               if (mismatch) begin
                  err_count_d = err_count_q + (WIDTH+1)'(1);
                  if (err_count_q == '0) begin
                     first_err_d = cur_pat;
                  end
               end
               hold_d = '0;
               if (idx_q == LAST_IDX) begin
                  state_d = DONE;
                  // Fold in the final pattern's result, not yet in err_count_q.
                  pass_d  = (err_count_q == '0) && !mismatch;
               end else begin
                  idx_d = idx_q + (WIDTH+1)'(1);
               end
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
            idx_d   = '0;
            hold_d  = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         mode_q      <= MODE_NAND;
         idx_q       <= '0;
         hold_q      <= '0;
         err_count_q <= '0;
         first_err_q <= '0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         hold_q      <= hold_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
         pass_q      <= pass_d;
      end
   end

   assign bus.dut_in    = (state_q == DRIVE) ? cur_pat : '0;
   assign bus.busy      = (state_q == DRIVE);
   assign bus.done      = (state_q == DONE);
   assign bus.pass      = pass_q;
   assign bus.err_count = err_count_q;
   assign bus.first_err = first_err_q;

   ref_consistent_a: assert property (@(posedge clk) disable iff (!rst_n) ref_ok);

`ifdef DE_MORGAN_SWEEP_GRAY_EN
   gray_step_a: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == DRIVE && state_d == DRIVE && idx_d != idx_q)
         |-> ($countones(pattern_of(idx_d[WIDTH-1:0]) ^ cur_pat) == 1));
`endif

endmodule

// File: tb/tb_de_morgan_sweep.sv
module tb_de_morgan_sweep;
   import de_morgan_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   de_morgan_sweep_if #(.WIDTH(2))  bus2 ();
   de_morgan_sweep_if #(.WIDTH(3))  bus3 ();
   de_morgan_sweep_if #(.WIDTH(16)) bus16 ();

   de_morgan_sweep #(.WIDTH(2),  .HOLD_CYCLES(2)) dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
   de_morgan_sweep #(.WIDTH(3),  .HOLD_CYCLES(1)) dut3  (.clk(clk), .rst_n(rst_n), .bus(bus3));
   de_morgan_sweep #(.WIDTH(16), .HOLD_CYCLES(1)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

   // gate under test for the 2-input engine: 0 NAND, 1 stuck0, 2 AND, 3 NOR, 4 stuck1
   int gate = 0;
   always_comb begin
      case (gate)
         0:       bus2.dut_out = ~(&bus2.dut_in);
         1:       bus2.dut_out = 1'b0;
         2:       bus2.dut_out = &bus2.dut_in;
         3:       bus2.dut_out = ~(|bus2.dut_in);
         4:       bus2.dut_out = 1'b1;
         default: bus2.dut_out = 1'b0;
      endcase
   end
   assign bus3.dut_out  = ~(&bus3.dut_in);
   assign bus16.dut_out = ~(&bus16.dut_in);

   int total  = 0;
   int passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   function automatic logic [1:0] pat2(input int i);
      logic [1:0] b;
      b = 2'(i);
`ifdef DE_MORGAN_SWEEP_GRAY_EN
      return b ^ (b >> 1);
`else
      return b;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      string name;
      logic  mode;
      int    gate;
      int    exp_err;
      int    exp_first;
      logic  exp_pass;
   } vec_t;

   vec_t vecs[7];

   task automatic sweep2(input vec_t v);
      int   busy_n;
      int   bad_seq;
      logic got_done;
      logic [31:0] err_at, first_at, pass_at;
      busy_n   = 0;
      bad_seq  = 0;
      got_done = 1'b0;
      err_at   = '1;
      first_at = '1;
      pass_at  = '1;
      step();
      bus2.mode  = v.mode;
      gate       = v.gate;
      bus2.start = 1'b1;
      step();
      bus2.start = 1'b0;
      bus2.mode  = ~v.mode;
      for (int c = 0; c < 64 && !got_done; c++) begin
         if (bus2.done) begin
            got_done = 1'b1;
            err_at   = 32'(bus2.err_count);
            first_at = 32'(bus2.first_err);
            pass_at  = 32'(bus2.pass);
         end else begin
            if (bus2.busy) begin
               if (bus2.dut_in !== pat2(busy_n / 2)) bad_seq++;
               busy_n++;
            end
            step();
         end
      end
      check({v.name, " busy_cycles"}, busy_n, 8);
      check({v.name, " dut_in_seq_errors"}, bad_seq, 0);
      check({v.name, " done_seen"}, 32'(got_done), 1);
      check({v.name, " err_count"}, err_at, v.exp_err);
      check({v.name, " first_err"}, first_at, v.exp_first);
      check({v.name, " pass"}, pass_at, 32'(v.exp_pass));
      step();
      check({v.name, " done_one_cycle"}, 32'(bus2.done), 0);
      check({v.name, " dut_in_idle"}, 32'(bus2.dut_in), 0);
   endtask

   initial begin
      int n;
      logic seen;

      bus2.start  = 1'b0; bus2.mode  = 1'b0;
      bus3.start  = 1'b0; bus3.mode  = 1'b0;
      bus16.start = 1'b0; bus16.mode = 1'b0;

      vecs[0] = '{"nand_ok",      MODE_NAND, 0, 0, 0, 1'b1};
      vecs[1] = '{"nand_stuck0",  MODE_NAND, 1, 3, 0, 1'b0};
      vecs[2] = '{"nor_and_gate", MODE_NOR,  2, 2, 0, 1'b0};
      vecs[3] = '{"nor_ok",       MODE_NOR,  3, 0, 0, 1'b1};
      vecs[4] = '{"nand_nor_gate",MODE_NAND, 3, 2, 1, 1'b0};
      vecs[5] = '{"nor_stuck1",   MODE_NOR,  4, 3, 1, 1'b0};
      vecs[6] = '{"nand_and_all", MODE_NAND, 2, 4, 0, 1'b0};

      #2;
      check("reset dut_in",    32'(bus2.dut_in), 0);
      check("reset busy",      32'(bus2.busy), 0);
      check("reset done",      32'(bus2.done), 0);
      check("reset pass",      32'(bus2.pass), 0);
      check("reset err_count", 32'(bus2.err_count), 0);
      check("reset first_err", 32'(bus2.first_err), 0);
      check("reset busy w16",  32'(bus16.busy), 0);
      #10 rst_n = 1'b1;

      foreach (vecs[i]) sweep2(vecs[i]);

      // start held high: DONE ignores it, the following IDLE cycle honours it
      step();
      gate = 0; bus2.mode = MODE_NAND; bus2.start = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 64 && !seen; c++) begin
         step();
         if (bus2.done) seen = 1'b1;
      end
      check("held_start first done", 32'(seen), 1);
      step();
      check("held_start busy after done", 32'(bus2.busy), 0);
      step();
      check("held_start restarted", 32'(bus2.busy), 1);
      bus2.start = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 64 && !seen; c++) begin
         step();
         if (bus2.done) seen = 1'b1;
      end
      check("held_start second done", 32'(seen), 1);
      check("held_start pass", 32'(bus2.pass), 1);

      // WIDTH=3: start pulse during busy is ignored
      step();
      bus3.mode = MODE_NAND; bus3.start = 1'b1;
      step();
      bus3.start = 1'b0;
      n = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (bus3.done) seen = 1'b1;
         else begin
            if (bus3.busy) n++;
            bus3.start = (n == 3);
            step();
         end
      end
      bus3.start = 1'b0;
      check("w3 busy_cycles with restart pulse", n, 8);
      check("w3 done_seen", 32'(seen), 1);
      check("w3 pass", 32'(bus3.pass), 1);
      step();
      step();
      check("w3 no restart", 32'(bus3.busy), 0);

      // WIDTH=3: reset mid-sweep
      bus3.start = 1'b1;
      step();
      bus3.start = 1'b0;
      n = 0;
      for (int c = 0; c < 20 && n < 5; c++) begin
         if (bus3.busy) n++;
         if (n < 5) step();
      end
      check("w3 busy before reset", 32'(bus3.busy), 1);
      rst_n = 1'b0;
      #1;
      check("w3 reset busy",      32'(bus3.busy), 0);
      check("w3 reset dut_in",    32'(bus3.dut_in), 0);
      check("w3 reset err_count", 32'(bus3.err_count), 0);
      check("w3 reset first_err", 32'(bus3.first_err), 0);
      check("w2 reset pass",      32'(bus2.pass), 0);
      #2 rst_n = 1'b1;
      step();
      check("w3 idle after reset", 32'(bus3.busy), 0);
      bus3.start = 1'b1;
      step();
      bus3.start = 1'b0;
      n = 0; seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         if (bus3.done) seen = 1'b1;
         else begin
            if (bus3.busy) n++;
            step();
         end
      end
      check("w3 clean busy_cycles", n, 8);
      check("w3 clean pass", 32'(bus3.pass), 1);
      check("w3 clean err_count", 32'(bus3.err_count), 0);

      // WIDTH=16 full sweep, index must not alias at 2^16
      step();
      bus16.mode = MODE_NAND; bus16.start = 1'b1;
      step();
      bus16.start = 1'b0;
      n = 0; seen = 1'b0;
      for (int c = 0; c < 70000 && !seen; c++) begin
         if (bus16.done) seen = 1'b1;
         else begin
            if (bus16.busy) n++;
            step();
         end
      end
      check("w16 done_seen", 32'(seen), 1);
      check("w16 busy_cycles", n, 65536);
      check("w16 err_count", 32'(bus16.err_count), 0);
      check("w16 first_err", 32'(bus16.first_err), 0);
      check("w16 pass", 32'(bus16.pass), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
